// File: rtl/fifo_pkg.sv
// Shared helpers and reset constants for the synchronous FIFO family.
package fifo_pkg;

    // Occupancy counter must represent 0..DEPTH inclusive, hence one extra bit.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    localparam logic RST_STICKY = 1'b0;

endpackage

// File: rtl/param_sync_fifo_if.sv
// Bus bundle for param_sync_fifo. The producer/consumer side is the master and the FIFO is the slave.
interface param_sync_fifo_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CNT_W = cnt_width(DEPTH);

    // Handshake: a write transfers when wr=1 and full=0 at the rising edge; a read
    // transfers when rd=1 and empty=0. Requests made against the flag are dropped
    // and latched into the sticky overflow/underflow bits.
    logic             wr;
    logic [WIDTH-1:0] data_in;
    logic             rd;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr, data_in, rd,
        input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr, data_in, rd,
        output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage with one synchronous write port and one read port.
// Read port is asynchronous when PARAM_SYNC_FIFO_FWFT_EN is defined, registered otherwise.
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
    logic unused_rd_ctrl;
    assign unused_rd_ctrl = ^{reset, re};
    assign rdata = mem[raddr];
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end
`endif

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO: pointers, occupancy count, threshold and sticky error flags.
// Define PARAM_SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is registered read.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic               clk,
    input  logic               reset,
    param_sync_fifo_if.slave   bus
);
    localparam int AW    = ptr_width(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_LEVEL);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;
    logic             wr_ok;
    logic             rd_ok;
    logic [WIDTH-1:0] mem_rdata;

    // Acceptance looks only at flags derived from pre-edge state, so a simultaneous
    // read on full cannot free space for the write in the same cycle (and vice versa).
    always_comb begin
        wr_ok = bus.wr && !bus.full;
        rd_ok = bus.rd && !bus.empty;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= RST_STICKY;
            underflow <= RST_STICKY;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            overflow  <= overflow  | (bus.wr && bus.full);
            underflow <= underflow | (bus.rd && bus.empty);
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (bus.data_in),
        .re    (rd_ok),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    assign bus.count        = count;
    assign bus.full         = (count == CNT_FULL);
    assign bus.empty        = (count == '0);
    assign bus.almost_full  = (count >= CNT_AF);
    assign bus.almost_empty = (count <= CNT_AE);
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;

`ifdef PARAM_SYNC_FIFO_FWFT_EN
    assign bus.data_out = bus.empty ? '0 : mem_rdata;
`else
    assign bus.data_out = mem_rdata;
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo (WIDTH=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2), both read modes.
module tb_param_sync_fifo;
    localparam int W = 8;
    localparam int D = 16;

    logic clk = 1'b0;
    logic reset;

    param_sync_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();

    param_sync_fifo #(
        .WIDTH    (W),
        .DEPTH    (D),
        .AF_LEVEL (14),
        .AE_LEVEL (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] exp_q[$];
    int           m_count;
    logic         m_ovf;
    logic         m_unf;
    logic [W-1:0] m_dout;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model_dout();
`ifdef PARAM_SYNC_FIFO_FWFT_EN
        return (exp_q.size() == 0) ? '0 : exp_q[0];
`else
        return m_dout;
`endif
    endfunction

    function automatic logic [W-1:0] burst_word(input int j);
        return (j < 5) ? W'(8'h20 + j) : W'(8'h30 + j - 5);
    endfunction

    // One clock of stimulus; the queue model tracks accepted traffic and every output.
    task automatic drive(input logic w, input logic [W-1:0] d, input logic r);
        logic wok;
        logic rok;
        wok = w && (m_count != D);
        rok = r && (m_count != 0);
        bus.wr      = w;
        bus.data_in = d;
        bus.rd      = r;
        @(posedge clk);
        #1;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        if (rok) m_dout = exp_q.pop_front();
        if (wok) exp_q.push_back(d);
        m_count = exp_q.size();
        m_ovf   = m_ovf | (w && !wok);
        m_unf   = m_unf | (r && !rok);
        check_eq("count", 32'(bus.count), 32'(m_count));
        check_eq("data_out", 32'(bus.data_out), 32'(model_dout()));
        check_eq("full_empty", {bus.full, bus.empty}, {m_count == D, m_count == 0});
        check_eq("almost", {bus.almost_full, bus.almost_empty}, {m_count >= 14, m_count <= 2});
        check_eq("sticky", {bus.overflow, bus.underflow}, {m_ovf, m_unf});
    endtask

    task automatic apply_reset(input logic w, input logic r);
        reset       = 1'b1;
        bus.wr      = w;
        bus.rd      = r;
        bus.data_in = 8'h77;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        exp_q.delete();
        m_count = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_dout  = '0;
        check_eq("rst_count", 32'(bus.count), 32'd0);
        check_eq("rst_empty", 32'(bus.empty), 32'd1);
        check_eq("rst_full", 32'(bus.full), 32'd0);
        check_eq("rst_af", 32'(bus.almost_full), 32'd0);
        check_eq("rst_ae", 32'(bus.almost_empty), 32'd1);
        check_eq("rst_ovf", 32'(bus.overflow), 32'd0);
        check_eq("rst_unf", 32'(bus.underflow), 32'd0);
        check_eq("rst_dout", 32'(bus.data_out), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr      = 1'b0;
        bus.rd      = 1'b0;
        bus.data_in = '0;
        reset       = 1'b1;
        m_count     = 0;
        m_ovf       = 1'b0;
        m_unf       = 1'b0;
        m_dout      = '0;
        repeat (2) @(posedge clk);
        #1;
        apply_reset(1'b0, 1'b0);

        // Fill 0x01..0x10, then one rejected write.
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, W'(i), 1'b0);
            check_eq("fill_count", 32'(bus.count), 32'(i));
            if (i == 13) check_eq("af_below", 32'(bus.almost_full), 32'd0);
            if (i == 14) check_eq("af_rise", 32'(bus.almost_full), 32'd1);
        end
        check_eq("full_at_16", 32'(bus.full), 32'd1);
        drive(1'b1, 8'hEE, 1'b0);
        check_eq("ovf_set", 32'(bus.overflow), 32'd1);
        check_eq("ovf_count", 32'(bus.count), 32'd16);
`ifdef PARAM_SYNC_FIFO_FWFT_EN
        check_eq("fwft_head", 32'(bus.data_out), 32'h01);
`endif

        // Drain all 16 in order, then one rejected read.
        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, '0, 1'b1);
`ifdef PARAM_SYNC_FIFO_FWFT_EN
            check_eq("drain_data", 32'(bus.data_out), (i < 16) ? 32'(i + 1) : 32'd0);
`else
            check_eq("drain_data", 32'(bus.data_out), 32'(i));
`endif
            if (i == 13) check_eq("ae_above", 32'(bus.almost_empty), 32'd0);
            if (i == 14) check_eq("ae_rise", 32'(bus.almost_empty), 32'd1);
        end
        check_eq("empty_after", 32'(bus.empty), 32'd1);
        drive(1'b0, '0, 1'b1);
        check_eq("unf_set", 32'(bus.underflow), 32'd1);
`ifdef PARAM_SYNC_FIFO_FWFT_EN
        check_eq("unf_dout", 32'(bus.data_out), 32'd0);
`else
        check_eq("unf_dout_hold", 32'(bus.data_out), 32'h10);
`endif

        // Steady state at count=5 with simultaneous wr/rd for 40 cycles (45 writes wrap twice).
        apply_reset(1'b0, 1'b0);
        for (int k = 0; k < 5; k++) drive(1'b1, burst_word(k), 1'b0);
        for (int k = 0; k < 40; k++) begin
            drive(1'b1, burst_word(k + 5), 1'b1);
            check_eq("steady_count", 32'(bus.count), 32'd5);
`ifdef PARAM_SYNC_FIFO_FWFT_EN
            check_eq("steady_data", 32'(bus.data_out), 32'(burst_word(k + 1)));
`else
            check_eq("steady_data", 32'(bus.data_out), 32'(burst_word(k)));
`endif
        end
        check_eq("steady_err", {bus.overflow, bus.underflow}, 32'd0);

        // wr+rd on full: read wins, 0xAA is dropped.
        apply_reset(1'b0, 1'b0);
        for (int i = 0; i < 16; i++) drive(1'b1, W'(8'h40 + i), 1'b0);
        drive(1'b1, 8'hAA, 1'b1);
        check_eq("full_rw_count", 32'(bus.count), 32'd15);
        check_eq("full_rw_ovf", 32'(bus.overflow), 32'd1);
`ifdef PARAM_SYNC_FIFO_FWFT_EN
        check_eq("full_rw_data", 32'(bus.data_out), 32'h41);
`else
        check_eq("full_rw_data", 32'(bus.data_out), 32'h40);
`endif
        for (int i = 0; i < 10; i++) drive(1'b0, '0, 1'b1);
        check_eq("partial_count", 32'(bus.count), 32'd5);

        // Reset in the middle of a wr+rd burst takes priority.
        for (int i = 0; i < 3; i++) drive(1'b1, W'(8'h60 + i), 1'b1);
        apply_reset(1'b1, 1'b1);

        // Single write after reset.
        drive(1'b1, 8'h5C, 1'b0);
`ifdef PARAM_SYNC_FIFO_FWFT_EN
        check_eq("single_dout", 32'(bus.data_out), 32'h5C);
`else
        check_eq("single_dout", 32'(bus.data_out), 32'h00);
`endif
        drive(1'b0, '0, 1'b1);
`ifdef PARAM_SYNC_FIFO_FWFT_EN
        check_eq("single_pop", 32'(bus.data_out), 32'h00);
`else
        check_eq("single_pop", 32'(bus.data_out), 32'h5C);
`endif
        check_eq("single_empty", 32'(bus.empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, number of entries; SHALL be a power of two >=2.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, count at or above which almost_full asserts.
REQ-004 Parameter AE_LEVEL, default 2, count at or below which almost_empty asserts.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 wr  input  1  write request.
REQ-008 data_in  input  WIDTH  write data.
REQ-009 rd  input  1  read request.
REQ-010 data_out  output  WIDTH  read data.
REQ-011 full / empty  output  1 each  occupancy flags.
REQ-012 almost_full / almost_empty  output  1 each  threshold flags.
REQ-013 count  output  CNT_W = clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 overflow / underflow  output  1 each  sticky error flags.

Function
REQ-015 Write accepted iff wr=1 and full=0 at the edge; data_in stored at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-016 Read accepted iff rd=1 and empty=0 at the edge; rd_ptr increments modulo DEPTH.
REQ-017 Acceptance SHALL use only the pre-edge flags: rd+wr on full -> read accepted, write rejected; rd+wr on empty -> write accepted, read rejected.
REQ-018 Pointers are clog2(DEPTH) bits and wrap DEPTH-1 -> 0 with no special-case logic.
REQ-019 count: +1 on write-only, -1 on read-only, unchanged on both or neither; never exceeds DEPTH or underflows 0.
REQ-020 full = (count==DEPTH), empty = (count==0), almost_full = (count>=AF_LEVEL), almost_empty = (count<=AE_LEVEL); all registered-state derived, glitch-free, valid same cycle as count.
REQ-021 Rejected write (wr=1, full=1) sets overflow; rejected read (rd=1, empty=1) sets underflow; both stay set until reset.
REQ-022 Standard mode: accepted read presents the head word on data_out one cycle after the edge; data_out holds its value when no read is accepted.
REQ-023 Write to an empty FIFO becomes readable the following cycle (empty deasserts one cycle after the write edge).

Reset
REQ-024 reset=1 at an edge SHALL clear wr_ptr, rd_ptr, count, overflow, underflow and data_out to 0; empty=1, almost_empty=1, full=0, almost_full=0 (AF_LEVEL>0).
REQ-025 Reset SHALL take priority over simultaneous wr/rd; storage contents are not cleared and are not observable after reset.

Configuration
REQ-026 Macro PARAM_SYNC_FIFO_FWFT_EN defined: first-word-fall-through; data_out equals the head entry whenever empty=0, rd pops it, next head visible the cycle after the pop, data_out is 0 while empty=1.
REQ-027 Macro undefined: standard registered-read behaviour of REQ-022; flag and count behaviour identical in both builds.

Structure
REQ-028 Shared package fifo_pkg SHALL hold the clog2-based width helper and the reset-value constants used by the FIFO family.
REQ-029 Storage SHALL be a sub-module fifo_mem: DEPTH x WIDTH, one synchronous write port, one read port (registered in standard mode, asynchronous in FWFT mode); pointer/count/flag logic stays in param_sync_fifo.

Verification
REQ-030 Reset then write 0x01..0x10 (DEPTH=16) -> full=1 and count=16 after the 16th write; 17th write sets overflow, memory unchanged.
REQ-031 Read all 16 -> data_out sequence 0x01..0x10 in order, empty=1 after last; further read sets underflow, data_out holds 0x10 (standard mode).
REQ-032 Continuous simultaneous wr/rd at count=5 for 40 cycles -> count stays 5, pointers wrap at least twice, data order preserved.
REQ-033 On full, assert wr+rd with data_in 0xAA -> read accepted, 0xAA rejected, overflow=1, count=15.
REQ-034 Fill to count=14 -> almost_full rises at 14 (AF_LEVEL=14); drain to 2 -> almost_empty rises at 2.
REQ-035 Assert reset mid-burst with wr=rd=1 -> next cycle count=0, empty=1, overflow=underflow=0; FWFT build: single write 0x5C -> data_out=0x5C one cycle later with no rd.
